// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller: state codes,
// default phase durations and a duration legality helper.
package tl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED     = 3'd2,
    PED_WALK    = 3'd3,
    PED_CLEAR   = 3'd4
  } tl_state_e;

  // Default phase durations in clk cycles
  localparam int T_GREEN_MIN_DEF = 8;
  localparam int T_YELLOW_DEF    = 3;
  localparam int T_ALLRED_DEF    = 2;
  localparam int T_WALK_DEF      = 6;
  localparam int T_CLEAR_DEF     = 4;
  localparam int CNT_W_DEF       = 8;

  // A duration must be at least one cycle and its value must fit the timer.
  function automatic bit dur_legal(input int dur, input int cnt_w);
    longint lim;
    lim = longint'(1) << cnt_w;
    return (dur >= 1) && (longint'(dur) < lim);
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Phase down-counter: loads (duration - 1) on state entry, counts down
// once per cycle and holds at zero; done flags the last cycle of a phase.
module tl_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins, otherwise decrement and saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register; reset value matches the phase the FSM resets into
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Pedestrian-crossing traffic light controller.
// Cars rest on green; a pedestrian request (rising edge of ped_btn) is
// latched and served after the minimum green time via yellow, all-red,
// walk and flashing clearance, then cars return to green.
//
// state       | meaning
// MAIN_GREEN  | cars go; leaves only when min green expired and a request exists
// MAIN_YELLOW | cars warned to stop
// ALL_RED     | intersection clearing before pedestrians
// PED_WALK    | pedestrians walk; new presses ignored
// PED_CLEAR   | pedestrian clearance flash; new presses ignored
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int T_GREEN_MIN = T_GREEN_MIN_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF,
  parameter int T_WALK      = T_WALK_DEF,
  parameter int T_CLEAR     = T_CLEAR_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ped_btn,
  output logic               car_red,
  output logic               car_yellow,
  output logic               car_green,
  output logic               ped_walk,
  output logic               ped_flash,
  output logic               req_pend,
  output logic [STATE_W-1:0] state
);

  localparam bit PARAMS_OK = dur_legal(T_GREEN_MIN, CNT_W) &&
                             dur_legal(T_YELLOW,    CNT_W) &&
                             dur_legal(T_ALLRED,    CNT_W) &&
                             dur_legal(T_WALK,      CNT_W) &&
                             dur_legal(T_CLEAR,     CNT_W);

  tl_state_e        state_q;
  tl_state_e        state_d;
  logic             ped_prev_q;
  logic             req_pend_q;
  logic             req_pend_d;
  logic             rise;
  logic             in_ped;
  logic             ped_entry;
  logic             done;
  logic             load;
  logic [CNT_W-1:0] load_val;

  assign rise      = ped_btn & ~ped_prev_q;
  assign in_ped    = (state_q == PED_WALK) || (state_q == PED_CLEAR);
  assign ped_entry = (state_d == PED_WALK) && (state_q != PED_WALK);
  assign load      = (state_d != state_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MAIN_GREEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; green also leaves on the very edge a press arrives
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if (done && (req_pend_q || rise)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (done) state_d = ALL_RED;
      ALL_RED:     if (done) state_d = PED_WALK;
      PED_WALK:    if (done) state_d = PED_CLEAR;
      PED_CLEAR:   if (done) state_d = MAIN_GREEN;
      default:     state_d = MAIN_GREEN;
    endcase
  end

  // Lamp decode of the state register only (Moore)
  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_walk   = 1'b0;
    ped_flash  = 1'b0;
    case (state_q)
      MAIN_GREEN:  car_green  = 1'b1;
      MAIN_YELLOW: car_yellow = 1'b1;
      ALL_RED:     car_red    = 1'b1;
      PED_WALK: begin
        car_red  = 1'b1;
        ped_walk = 1'b1;
      end
      PED_CLEAR: begin
        car_red   = 1'b1;
        ped_flash = 1'b1;
      end
      // Unused codes keep cars stopped for the one cycle before recovery
      default:     car_red    = 1'b1;
    endcase
  end

  // Duration of the phase being entered, minus one, for the timer load
  always_comb begin
    load_val = CNT_W'(T_GREEN_MIN - 1);
    case (state_d)
      MAIN_YELLOW: load_val = CNT_W'(T_YELLOW - 1);
      ALL_RED:     load_val = CNT_W'(T_ALLRED - 1);
      PED_WALK:    load_val = CNT_W'(T_WALK - 1);
      PED_CLEAR:   load_val = CNT_W'(T_CLEAR - 1);
      default:     load_val = CNT_W'(T_GREEN_MIN - 1);
    endcase
  end

  // Request latch: clearing on walk entry has priority so a press in
  // ALL_RED on that same edge counts as served by this walk
  always_comb begin
    req_pend_d = req_pend_q;
    if (ped_entry) begin
      req_pend_d = 1'b0;
    end else if (rise && !in_ped) begin
      req_pend_d = 1'b1;
    end
  end

  // Button history and request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_prev_q <= 1'b0;
      req_pend_q <= 1'b0;
    end else begin
      ped_prev_q <= ped_btn;
      req_pend_q <= req_pend_d;
    end
  end

  tl_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(T_GREEN_MIN - 1)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .done    (done)
  );

  assign req_pend = req_pend_q;
  assign state    = state_q;

  a_params_legal: assert property (@(posedge clk) PARAMS_OK)
    else $error("traffic_light_ctrl: a phase duration is 0 or does not fit CNT_W");

  a_one_car_lamp: assert property (@(posedge clk) disable iff (!reset)
                                   $onehot({car_red, car_yellow, car_green}))
    else $error("traffic_light_ctrl: car lamps not one-hot");

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus random button
// activity, checked against a phase/elapsed-time model of the light.
module tb_traffic_light_ctrl;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ped_btn;
  logic       car_red, car_yellow, car_green, ped_walk, ped_flash, req_pend;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Model: phase index 0..4, cycles already spent in it, latched request
  int m_phase;
  int m_age;
  bit m_req;
  bit m_prev;
  int dur[5] = '{T_GREEN_MIN_DEF, T_YELLOW_DEF, T_ALLRED_DEF, T_WALK_DEF, T_CLEAR_DEF};
  // {red, yellow, green, walk, flash} per phase
  logic [4:0] lamp_tab[5] = '{5'b00100, 5'b01000, 5'b10000, 5'b10010, 5'b10001};

  traffic_light_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .ped_btn   (ped_btn),
    .car_red   (car_red),
    .car_yellow(car_yellow),
    .car_green (car_green),
    .ped_walk  (ped_walk),
    .ped_flash (ped_flash),
    .req_pend  (req_pend),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lamps();
    return {car_red, car_yellow, car_green, ped_walk, ped_flash};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_req   = 1'b0;
    m_prev  = 1'b0;
  endtask

  task automatic model_edge(input bit b);
    bit rise, expired, adv;
    int nxt;
    rise    = b && !m_prev;
    expired = (m_age + 1 >= dur[m_phase]);
    adv     = expired && (m_phase != 0 || m_req || rise);
    nxt     = (m_phase + 1) % 5;
    if (adv && nxt == 3)            m_req = 1'b0;
    else if (rise && m_phase < 3)   m_req = 1'b1;
    if (adv) begin
      m_phase = nxt;
      m_age   = 0;
    end else begin
      m_age++;
    end
    m_prev = b;
  endtask

  task automatic check_model();
    chk("model_state", {5'b0, state}, m_phase[7:0]);
    chk("model_lamps", {3'b0, lamps()}, {3'b0, lamp_tab[m_phase]});
    chk("model_req_pend", {7'b0, req_pend}, {7'b0, m_req});
  endtask

  // One cycle: drive the button, check this cycle, then take the edge
  task automatic step(input bit b);
    ped_btn = b;
    check_model();
    @(posedge clk);
    #1;
    model_edge(b);
  endtask

  // Reset pulse; returns at the start of cycle 0 after release
  task automatic apply_reset(input bit btn);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    ped_btn = btn;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lamps", {3'b0, lamps()}, 8'h04);
    chk("rst_req_pend", {7'b0, req_pend}, 8'h00);
    reset = 1'b1;
  endtask

  initial begin
    bit       reached;
    bit       b;
    bit       was_walk;
    int       walks;
    logic [4:0] exp_l;

    reset   = 1'b0;
    ped_btn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {5'b0, state}, 8'h00);
    chk("reset_lamps", {3'b0, lamps()}, 8'h04);
    chk("reset_req_pend", {7'b0, req_pend}, 8'h00);
    reset = 1'b1;

    // Idle: no presses for 50 cycles keeps cars on green
    for (int c = 0; c < 50; c++) begin
      chk("idle_green", {7'b0, car_green}, 8'h01);
      step(1'b0);
    end
    chk("idle_state", {5'b0, state}, 8'h00);
    chk("idle_req_pend", {7'b0, req_pend}, 8'h00);

    // Press at cycle 2: explicit timeline of the whole crossing cycle
    apply_reset(1'b0);
    for (int c = 0; c <= 30; c++) begin
      exp_l = {(c >= 11 && c <= 22), (c >= 8 && c <= 10), (c < 8 || c >= 23),
               (c >= 13 && c <= 18), (c >= 19 && c <= 22)};
      chk("timeline_lamps", {3'b0, lamps()}, {3'b0, exp_l});
      chk("timeline_req_pend", {7'b0, req_pend}, {7'b0, (c >= 3 && c <= 12)});
      step(c == 2);
    end

    // Press at cycle 20, after min green: yellow on the next cycle
    apply_reset(1'b0);
    for (int c = 0; c <= 21; c++) begin
      if (c == 20) chk("late_press_green", {7'b0, car_green}, 8'h01);
      if (c == 21) chk("late_press_yellow", {7'b0, car_yellow}, 8'h01);
      step(c == 20);
    end
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (state == 3'd3) reached = 1'b1;
      else step(1'b0);
    end
    chk("reach_walk", {7'b0, reached}, 8'h01);
    // Press during walk must be ignored
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("walk_press_ignored", {7'b0, req_pend}, 8'h00);
    for (int c = 0; c < 40; c++) step(1'b0);
    chk("after_walk_state", {5'b0, state}, 8'h00);
    chk("after_walk_green", {7'b0, car_green}, 8'h01);

    // Button held from release: exactly one walk
    apply_reset(1'b1);
    walks    = 0;
    was_walk = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (ped_walk && !was_walk) walks++;
      was_walk = ped_walk;
      step(c < 30);
    end
    chk("held_walk_count", walks[7:0], 8'h01);

    // Reset in the middle of a walk takes effect without a clock edge
    apply_reset(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (state == 3'd3) reached = 1'b1;
      else step(1'b0);
    end
    chk("reach_walk2", {7'b0, reached}, 8'h01);
    step(1'b0);
    step(1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_green", {7'b0, car_green}, 8'h01);
    chk("midrst_walk", {7'b0, ped_walk}, 8'h00);
    chk("midrst_req_pend", {7'b0, req_pend}, 8'h00);
    chk("midrst_state", {5'b0, state}, 8'h00);
    model_reset();
    ped_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    walks    = 0;
    was_walk = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ped_walk && !was_walk) walks++;
      was_walk = ped_walk;
      step(c == 2);
    end
    chk("resume_walk_count", walks[7:0], 8'h01);

    // Random button activity against the model
    apply_reset(1'b0);
    b = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
